// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the ARM7-style ALU: 4-bit opcode
//             encodings and the bit order of the {N,Z,C,V} flag vector.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   // Opcode encodings carried on alu_control
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_ADDS = 4'd2;
   localparam logic [3:0] OP_SUBS = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_MVN  = 4'd7;
   localparam logic [3:0] OP_CMP  = 4'd8;
   localparam logic [3:0] OP_CMN  = 4'd9;
   localparam logic [3:0] OP_TST  = 4'd10;
   localparam logic [3:0] OP_TEQ  = 4'd11;
   localparam logic [3:0] OP_MOV  = 4'd12;
   localparam logic [3:0] OP_BIC  = 4'd13;
   localparam logic [3:0] OP_ADC  = 4'd14;
   localparam logic [3:0] OP_SBC  = 4'd15;

   // Flag vector bit positions, packed as {N,Z,C,V}
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_adder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_adder
//  Purpose  : Combinational (WIDTH+1)-bit adder computing
//             a + (sub ? ~b : b) + cin, with carry-out and signed overflow.
//  Ports    : i_a     in  WIDTH  first operand
//             i_b     in  WIDTH  second operand (inverted internally on sub)
//             i_sub   in  1      invert i_b before adding
//             i_cin   in  1      carry in
//             o_sum   out WIDTH  wrapped sum
//             o_cout  out 1      carry out of the top bit
//             o_ovf   out 1      signed overflow
//  Revision : 1.0  initial release
// ============================================================================
module alu_adder
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sub,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH:0]   w_full;

   assign w_b_eff = i_sub ? ~i_b : i_b;
   assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_cin};
   assign o_sum   = w_full[WIDTH-1:0];
   assign o_cout  = w_full[WIDTH];
   // Overflow: both addends share a sign but the sum's sign differs
   assign o_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                    (w_full[WIDTH-1] != i_a[WIDTH-1]);

endmodule : alu_adder
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Purpose  : 32-bit ARM7-style integer ALU with registered result and
//             persistent NZCV flags (ADC/SBC consume the stored carry).
//  Ports    : clk            in  1      rising-edge clock
//             rst_n          in  1      synchronous active-low reset
//             operand_a      in  WIDTH  first operand (Rn)
//             operand_b      in  WIDTH  second operand
//             alu_control    in  4      opcode (see alu_pkg)
//             result         out WIDTH  registered result
//             zero_flag      out 1      registered Z
//             carry_flag     out 1      registered C
//             overflow_flag  out 1      registered V
//             negative_flag  out 1      registered N
//  Revision : 1.0  initial release
// ============================================================================
module alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [3:0]       alu_control,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
   output logic             carry_flag,
   output logic             overflow_flag,
   output logic             negative_flag
);

   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;   // {N,Z,C,V}

   logic             w_sub;
   logic             w_cin;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_ovf;

   logic [WIDTH-1:0] w_val;
   logic             w_wr_res;
   logic             w_upd_nz;
   logic             w_upd_cv;

   // Adder control: SBC uses the stored C directly as carry-in, which
   // yields a - b - !C through the inverted-b path.
   always_comb begin
      w_sub = 1'b0;
      w_cin = 1'b0;
      case (alu_control)
         OP_SUB, OP_SUBS, OP_CMP: begin
            w_sub = 1'b1;
            w_cin = 1'b1;
         end
         OP_SBC: begin
            w_sub = 1'b1;
            w_cin = r_flags[FLAG_C];
         end
         OP_ADC: begin
            w_cin = r_flags[FLAG_C];
         end
         default: ;
      endcase
   end

   alu_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .i_a    (operand_a),
      .i_b    (operand_b),
      .i_sub  (w_sub),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_ovf  (w_ovf)
   );

   // Op mux: selects the computed value and which registers it may update
   always_comb begin
      w_val    = w_sum;
      w_wr_res = 1'b0;
      w_upd_nz = 1'b0;
      w_upd_cv = 1'b0;
      case (alu_control)
         OP_ADD, OP_SUB: begin
            w_wr_res = 1'b1;
         end
         OP_ADDS, OP_SUBS, OP_ADC, OP_SBC: begin
            w_wr_res = 1'b1;
            w_upd_nz = 1'b1;
            w_upd_cv = 1'b1;
         end
         OP_CMP, OP_CMN: begin
            w_upd_nz = 1'b1;
            w_upd_cv = 1'b1;
         end
         OP_AND: begin
            w_val    = operand_a & operand_b;
            w_wr_res = 1'b1;
            w_upd_nz = 1'b1;
         end
         OP_OR: begin
            w_val    = operand_a | operand_b;
            w_wr_res = 1'b1;
            w_upd_nz = 1'b1;
         end
         OP_XOR: begin
            w_val    = operand_a ^ operand_b;
            w_wr_res = 1'b1;
            w_upd_nz = 1'b1;
         end
         OP_MVN: begin
            w_val    = ~operand_b;
            w_wr_res = 1'b1;
            w_upd_nz = 1'b1;
         end
         OP_TST: begin
            w_val    = operand_a & operand_b;
            w_upd_nz = 1'b1;
         end
         OP_TEQ: begin
            w_val    = operand_a ^ operand_b;
            w_upd_nz = 1'b1;
         end
         OP_MOV: begin
            w_val    = operand_b;
            w_wr_res = 1'b1;
            w_upd_nz = 1'b1;
         end
         OP_BIC: begin
            w_val    = operand_a & ~operand_b;
            w_wr_res = 1'b1;
            w_upd_nz = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result <= '0;
         r_flags  <= 4'b0000;
      end else begin
         if (w_wr_res) begin
            r_result <= w_val;
         end
         if (w_upd_nz) begin
            r_flags[FLAG_N] <= w_val[WIDTH-1];
            r_flags[FLAG_Z] <= (w_val == '0);
         end
         if (w_upd_cv) begin
            r_flags[FLAG_C] <= w_cout;
            r_flags[FLAG_V] <= w_ovf;
         end
      end
   end

   assign result        = r_result;
   assign negative_flag = r_flags[FLAG_N];
   assign zero_flag     = r_flags[FLAG_Z];
   assign carry_flag    = r_flags[FLAG_C];
   assign overflow_flag = r_flags[FLAG_V];

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu
//  Purpose  : Self-checking scoreboard bench for alu. Directed vectors push
//             hand-computed expected {result, NZCV} into a queue; a monitor
//             pops and compares after each clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu;
   import alu_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic [3:0]  fl;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [3:0]  alu_control;
   logic [31:0] result;
   logic        zero_flag;
   logic        carry_flag;
   logic        overflow_flag;
   logic        negative_flag;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   alu #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .alu_control   (alu_control),
      .result        (result),
      .zero_flag     (zero_flag),
      .carry_flag    (carry_flag),
      .overflow_flag (overflow_flag),
      .negative_flag (negative_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one op on the falling edge and record what the next rising edge
   // must produce.
   task automatic issue(input string nm, input logic rn, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef);
      exp_t e;
      @(negedge clk);
      rst_n       = rn;
      alu_control = op;
      operand_a   = a;
      operand_b   = b;
      e.name = nm;
      e.res  = er;
      e.fl   = ef;
      q.push_back(e);
   endtask

   // Monitor: outputs are valid after every edge that sampled an issued op
   always @(posedge clk) begin
      exp_t        e;
      logic [3:0]  act_fl;
      #1;
      if (q.size() != 0) begin
         e      = q.pop_front();
         act_fl = {negative_flag, zero_flag, carry_flag, overflow_flag};
         n_chk++;
         if (result === e.res) n_pass++;
         else $display("FAIL %s result: got %08h expected %08h", e.name, result, e.res);
         n_chk++;
         if (act_fl === e.fl) n_pass++;
         else $display("FAIL %s NZCV: got %04b expected %04b", e.name, act_fl, e.fl);
      end
   end

   initial begin
      int guard;
      rst_n       = 1'b0;
      operand_a   = '0;
      operand_b   = '0;
      alu_control = OP_ADD;

      // Reset held for two cycles while ADDS 5+5 is presented
      issue("rst0",      1'b0, OP_ADDS, 32'd5, 32'd5, 32'd0, 4'b0000);
      issue("rst1",      1'b0, OP_ADDS, 32'd5, 32'd5, 32'd0, 4'b0000);
      issue("rst_rel",   1'b1, OP_ADDS, 32'd5, 32'd5, 32'd10, 4'b0000);
      // Wrap-around sets Z and C
      issue("adds_wrap", 1'b1, OP_ADDS, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110);
      // Non-S add leaves flags alone
      issue("add",       1'b1, OP_ADD,  32'd10, 32'd20, 32'd30, 4'b0110);
      issue("subs_pos",  1'b1, OP_SUBS, 32'd30, 32'd15, 32'd15, 4'b0010);
      issue("subs_neg",  1'b1, OP_SUBS, 32'hFFFF_FFF6, 32'd5, 32'hFFFF_FFF1, 4'b1010);
      issue("subs_ovf",  1'b1, OP_SUBS, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011);
      // Logical ops: C=1,V=1 must survive
      issue("and",       1'b1, OP_AND,  32'hC, 32'hA, 32'h8, 4'b0011);
      issue("or",        1'b1, OP_OR,   32'hC, 32'hA, 32'hE, 4'b0011);
      issue("xor",       1'b1, OP_XOR,  32'hC, 32'hA, 32'h6, 4'b0011);
      issue("mvn",       1'b1, OP_MVN,  32'h1234, 32'hC, 32'hFFFF_FFF3, 4'b1011);
      issue("bic",       1'b1, OP_BIC,  32'hC, 32'hA, 32'h4, 4'b0011);
      issue("sub",       1'b1, OP_SUB,  32'd100, 32'd1, 32'd99, 4'b0011);
      issue("mov",       1'b1, OP_MOV,  32'hDEAD, 32'h55, 32'h55, 4'b0011);
      // Flag-only ops keep result at 0x55
      issue("cmp",       1'b1, OP_CMP,  32'd10, 32'd20, 32'h55, 4'b1000);
      issue("tst",       1'b1, OP_TST,  32'hC, 32'h3, 32'h55, 4'b0100);
      issue("teq",       1'b1, OP_TEQ,  32'd5, 32'd5, 32'h55, 4'b0100);
      issue("cmn",       1'b1, OP_CMN,  32'h7FFF_FFFF, 32'd1, 32'h55, 4'b1001);
      // Carry chain
      issue("adds_c1",   1'b1, OP_ADDS, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110);
      issue("adc_c1",    1'b1, OP_ADC,  32'd1, 32'd1, 32'd3, 4'b0000);
      issue("adc_c0",    1'b1, OP_ADC,  32'd1, 32'd1, 32'd2, 4'b0000);
      issue("subs_c0",   1'b1, OP_SUBS, 32'd5, 32'd6, 32'hFFFF_FFFF, 4'b1000);
      issue("sbc_c0",    1'b1, OP_SBC,  32'd10, 32'd3, 32'd6, 4'b0010);
      issue("sbc_c1",    1'b1, OP_SBC,  32'd10, 32'd3, 32'd7, 4'b0010);
      // Reset mid-stream beats the opcode, then Z from MOV 0
      issue("rst_mid",   1'b0, OP_ADDS, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0000);
      issue("mov_zero",  1'b1, OP_MOV,  32'd7, 32'd0, 32'd0, 4'b0100);

      guard = 0;
      while (q.size() != 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_alu
`default_nettype wire
